// File: rtl/stop_watch_seq.sv
// stop_watch_seq
//   Turns discrete start / stop / clear commands into the right number of
//   presses of the single stop_watch button. The watch cycles
//   IDLE -> CLEAR -> RUNNING -> IDLE on each press. Every press is confirmed
//   against the mode the watch reports. If the mode does not follow, the
//   command ends in an error pulse. Also captures one lap time on request
//   while the watch is running.
//
// Ports
//   clk          system clock
//   Rst_i        asynchronous active-high reset
//   start_i      command pulse: go to RUNNING
//   stop_i       command pulse: go to IDLE
//   clear_i      command pulse: go to CLEAR (priority clear > stop > start)
//   lap_i        pulse: capture sw_time_i if the watch is RUNNING
//   sw_mode_i    watch mode, one-hot IDLE=100 CLEAR=010 RUNNING=001
//   sw_time_i    watch time
//   button_o     drives the watch button
//   busy_o       command in progress
//   done_o       one-cycle pulse: target mode reached
//   err_o        one-cycle pulse: timeout, unexpected or illegal mode
//   lap_o        last captured time
//   lap_valid_o  lap_o holds a valid capture

module stop_watch_seq #(
    parameter int PRESS_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int WAIT_TIMEOUT  = 10
) (
    input  logic       clk,
    input  logic       Rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       clear_i,
    input  logic       lap_i,
    input  logic [2:0] sw_mode_i,
    input  logic [4:0] sw_time_i,
    output logic       button_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [4:0] lap_o,
    output logic       lap_valid_o
);

    localparam logic [2:0] MODE_IDLE  = 3'b100;
    localparam logic [2:0] MODE_CLEAR = 3'b010;
    localparam logic [2:0] MODE_RUN   = 3'b001;

    localparam int CNT_MAX_PS = (PRESS_CYCLES > SETTLE_CYCLES) ? PRESS_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_PS > WAIT_TIMEOUT) ? CNT_MAX_PS : WAIT_TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRESS_LAST  = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_READY,
        S_PRESS,
        S_WAIT,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic logic is_legal(input logic [2:0] m);
        return (m == MODE_IDLE) || (m == MODE_CLEAR) || (m == MODE_RUN);
    endfunction

    // Mode the watch moves to after one press.
    function automatic logic [2:0] next_mode(input logic [2:0] m);
        case (m)
            MODE_IDLE:  return MODE_CLEAR;
            MODE_CLEAR: return MODE_RUN;
            default:    return MODE_IDLE;
        endcase
    endfunction

    // Forward distance from cur to tgt around the three-mode cycle.
    function automatic logic [1:0] press_count(input logic [2:0] cur, input logic [2:0] tgt);
        if (tgt == cur)
            return 2'd0;
        else if (tgt == next_mode(cur))
            return 2'd1;
        else
            return 2'd2;
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       presses_q;
    logic [2:0]       tgt_q;
    logic [2:0]       cur_mode_q;
    logic [2:0]       exp_mode_q;
    logic             button_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [4:0]       lap_q;
    logic             lap_valid_q;

    logic             cmd_valid_d;
    logic [2:0]       cmd_tgt_d;
    logic [1:0]       cmd_presses_d;

    always_comb begin
        cmd_valid_d   = clear_i | stop_i | start_i;
        cmd_tgt_d     = MODE_RUN;
        if (clear_i)
            cmd_tgt_d = MODE_CLEAR;
        else if (stop_i)
            cmd_tgt_d = MODE_IDLE;
        cmd_presses_d = press_count(sw_mode_i, cmd_tgt_d);
    end

    always_ff @(posedge clk or posedge Rst_i) begin
        if (Rst_i) begin
            state_q    <= S_READY;
            cnt_q      <= '0;
            presses_q  <= '0;
            tgt_q      <= MODE_IDLE;
            cur_mode_q <= MODE_IDLE;
            exp_mode_q <= MODE_IDLE;
            button_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_READY: begin
                    if (cmd_valid_d) begin
                        tgt_q <= cmd_tgt_d;
                        if (!is_legal(sw_mode_i)) begin
                            // Cannot plan presses from a corrupt mode: report and stay.
                            err_q <= 1'b1;
                        end else if (cmd_presses_d == 2'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            presses_q  <= cmd_presses_d;
                            cur_mode_q <= sw_mode_i;
                            exp_mode_q <= next_mode(sw_mode_i);
                            cnt_q      <= '0;
                            button_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_PRESS;
                        end
                    end
                end
                S_PRESS: begin
                    if (cnt_q == PRESS_LAST) begin
                        button_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (sw_mode_i == exp_mode_q) begin
                        presses_q <= presses_q - 2'd1;
                        cnt_q     <= '0;
                        state_q   <= S_SETTLE;
                    end else if (!is_legal(sw_mode_i) || (sw_mode_i != cur_mode_q)) begin
                        // Watch moved somewhere we did not ask for.
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else if (cnt_q == WAIT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q <= '0;
                        if (presses_q != 2'd0) begin
                            // The confirmed mode becomes the base for the next press.
                            cur_mode_q <= exp_mode_q;
                            exp_mode_q <= next_mode(exp_mode_q);
                            button_q   <= 1'b1;
                            state_q    <= S_PRESS;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE, S_ERROR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_READY;
                end
                default: begin
                    button_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_READY;
                end
            endcase
        end
    end

    // A completed clear (including the zero-press case) wipes the lap,
    // taking precedence over a capture in the same cycle.
    always_ff @(posedge clk or posedge Rst_i) begin
        if (Rst_i) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (done_q && (tgt_q == MODE_CLEAR)) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (lap_i && (sw_mode_i == MODE_RUN)) begin
            lap_q       <= sw_time_i;
            lap_valid_q <= 1'b1;
        end
    end

    assign button_o    = button_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign lap_o       = lap_q;
    assign lap_valid_o = lap_valid_q;

endmodule

// File: tb/tb_stop_watch_seq.sv
module tb_stop_watch_seq;

    localparam logic [2:0] M_IDLE  = 3'b100;
    localparam logic [2:0] M_CLEAR = 3'b010;
    localparam logic [2:0] M_RUN   = 3'b001;

    logic       clk = 1'b0;
    logic       Rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       lap_i = 1'b0;
    logic [2:0] sw_mode_i;
    logic [4:0] sw_time_i = 5'd0;
    logic       button_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [4:0] lap_o;
    logic       lap_valid_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stop_watch_seq #(
        .PRESS_CYCLES (1),
        .SETTLE_CYCLES(2),
        .WAIT_TIMEOUT (10)
    ) dut (
        .clk        (clk),
        .Rst_i      (Rst_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .clear_i    (clear_i),
        .lap_i      (lap_i),
        .sw_mode_i  (sw_mode_i),
        .sw_time_i  (sw_time_i),
        .button_o   (button_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .lap_o      (lap_o),
        .lap_valid_o(lap_valid_o)
    );

    // Simple stop_watch stand-in: advances one mode per button press when
    // enabled, otherwise follows the manually driven mode.
    logic       model_en = 1'b0;
    logic [2:0] man_mode = M_IDLE;
    logic [2:0] model_mode = M_IDLE;
    logic       model_btn_prev = 1'b0;

    always @(posedge clk) begin
        if (!model_en)
            model_mode <= man_mode;
        else if (button_o && !model_btn_prev)
            model_mode <= (model_mode == M_IDLE)  ? M_CLEAR :
                          (model_mode == M_CLEAR) ? M_RUN : M_IDLE;
        model_btn_prev <= button_o;
    end

    assign sw_mode_i = model_en ? model_mode : man_mode;

    // Event counters sampled on the falling edge.
    int   rise_cnt = 0;
    int   high_cnt = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic mon_btn_prev = 1'b0;

    always @(negedge clk) begin
        if (button_o && !mon_btn_prev) rise_cnt++;
        if (button_o) high_cnt++;
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
        mon_btn_prev = button_o;
    end

    int s_rise, s_high, s_done, s_err;

    task automatic snap();
        @(negedge clk);
        #2;
        s_rise = rise_cnt;
        s_high = high_cnt;
        s_done = done_cnt;
        s_err  = err_cnt;
    endtask

    // One-cycle command pulse; returns at the falling edge of cycle T+1.
    task automatic send(input bit st, input bit sp, input bit cl, input bit lp);
        @(negedge clk);
        start_i = st; stop_i = sp; clear_i = cl; lap_i = lp;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; lap_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic use_model(input logic [2:0] m);
        model_en = 1'b0;
        man_mode = m;
        repeat (2) @(negedge clk);
        model_en = 1'b1;
    endtask

    task automatic test_reset();
        Rst_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (button_o !== 1'b0) begin failures++; $display("FAIL reset_button got=%b exp=0", button_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done_o, err_o); end
        checks++; if (lap_o !== 5'd0 || lap_valid_o !== 1'b0) begin failures++; $display("FAIL reset_lap got=%0d/%b exp=0/0", lap_o, lap_valid_o); end
        Rst_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || button_o !== 1'b0) begin failures++; $display("FAIL post_reset_idle got busy=%b btn=%b exp=0/0", busy_o, button_o); end
    endtask

    task automatic test_start_from_idle();
        bit ok;
        use_model(M_IDLE);
        snap();
        send(1, 0, 0, 0);
        checks++; if (button_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("FAIL start_first_press got btn=%b busy=%b exp=1/1", button_o, busy_o); end
        wait_idle(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL start_complete got=timeout exp=idle"); end
        repeat (3) @(negedge clk);
        #2;
        checks++; if (rise_cnt - s_rise !== 2) begin failures++; $display("FAIL start_presses got=%0d exp=2", rise_cnt - s_rise); end
        checks++; if (high_cnt - s_high !== 2) begin failures++; $display("FAIL start_press_width got=%0d exp=2", high_cnt - s_high); end
        checks++; if (done_cnt - s_done !== 1 || err_cnt - s_err !== 0) begin failures++; $display("FAIL start_done_err got=%0d/%0d exp=1/0", done_cnt - s_done, err_cnt - s_err); end
        checks++; if (sw_mode_i !== M_RUN) begin failures++; $display("FAIL start_mode got=%b exp=001", sw_mode_i); end
    endtask

    task automatic test_stop();
        bit ok;
        snap();
        send(0, 1, 0, 0);
        wait_idle(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stop_complete got=timeout exp=idle"); end
        repeat (3) @(negedge clk);
        #2;
        checks++; if (rise_cnt - s_rise !== 1 || done_cnt - s_done !== 1) begin failures++; $display("FAIL stop_presses_done got=%0d/%0d exp=1/1", rise_cnt - s_rise, done_cnt - s_done); end
        checks++; if (sw_mode_i !== M_IDLE) begin failures++; $display("FAIL stop_mode got=%b exp=100", sw_mode_i); end
        snap();
        send(0, 1, 0, 0);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || button_o !== 1'b0) begin failures++; $display("FAIL stop_zero_t1 got done=%b busy=%b btn=%b exp=1/0/0", done_o, busy_o, button_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL stop_zero_t2 got done=%b busy=%b exp=0/0", done_o, busy_o); end
        #2;
        checks++; if (rise_cnt - s_rise !== 0) begin failures++; $display("FAIL stop_zero_presses got=%0d exp=0", rise_cnt - s_rise); end
    endtask

    task automatic test_priority_and_busy();
        bit ok;
        snap();
        send(1, 1, 1, 0);
        checks++; if (button_o !== 1'b1) begin failures++; $display("FAIL prio_press got=%b exp=1", button_o); end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL prio_complete got=timeout exp=idle"); end
        repeat (5) @(negedge clk);
        #2;
        checks++; if (rise_cnt - s_rise !== 1 || done_cnt - s_done !== 1) begin failures++; $display("FAIL prio_presses_done got=%0d/%0d exp=1/1", rise_cnt - s_rise, done_cnt - s_done); end
        checks++; if (sw_mode_i !== M_CLEAR) begin failures++; $display("FAIL prio_mode got=%b exp=010", sw_mode_i); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL prio_busy_end got=%b exp=0", busy_o); end
    endtask

    task automatic test_timeout_and_illegal();
        int   err_cyc;
        int   errs;
        int   highs;
        logic busy13;
        model_en = 1'b0;
        man_mode = M_IDLE;
        repeat (2) @(negedge clk);
        send(0, 0, 1, 0);
        checks++; if (button_o !== 1'b1) begin failures++; $display("FAIL tmo_press got=%b exp=1", button_o); end
        err_cyc = -1; errs = 0; highs = 0; busy13 = 1'bx;
        for (int cyc = 2; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (button_o) highs++;
            if (err_o) begin
                errs++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (cyc == 13) busy13 = busy_o;
        end
        checks++; if (err_cyc !== 12) begin failures++; $display("FAIL tmo_err_cycle got=%0d exp=12", err_cyc); end
        checks++; if (errs !== 1 || highs !== 0) begin failures++; $display("FAIL tmo_err_once got errs=%0d highs=%0d exp=1/0", errs, highs); end
        checks++; if (busy13 !== 1'b0) begin failures++; $display("FAIL tmo_ready got busy=%b exp=0", busy13); end
        man_mode = 3'b011;
        send(0, 0, 1, 0);
        checks++; if (err_o !== 1'b1 || button_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL illegal_t1 got err=%b btn=%b busy=%b exp=1/0/0", err_o, button_o, busy_o); end
        @(negedge clk);
        checks++; if (err_o !== 1'b0 || button_o !== 1'b0) begin failures++; $display("FAIL illegal_t2 got err=%b btn=%b exp=0/0", err_o, button_o); end
        man_mode = M_IDLE;
    endtask

    task automatic test_lap();
        bit ok;
        model_en = 1'b0;
        man_mode = M_RUN;
        sw_time_i = 5'd15;
        send(0, 0, 0, 1);
        checks++; if (lap_o !== 5'd15 || lap_valid_o !== 1'b1) begin failures++; $display("FAIL lap_capture got=%0d/%b exp=15/1", lap_o, lap_valid_o); end
        man_mode = M_IDLE;
        sw_time_i = 5'd23;
        send(0, 0, 0, 1);
        checks++; if (lap_o !== 5'd15 || lap_valid_o !== 1'b1) begin failures++; $display("FAIL lap_ignore_idle got=%0d/%b exp=15/1", lap_o, lap_valid_o); end
        model_en = 1'b1;
        send(0, 0, 1, 0);
        checks++; if (lap_o !== 5'd15) begin failures++; $display("FAIL lap_hold_busy got=%0d exp=15", lap_o); end
        wait_idle(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lap_clear_complete got=timeout exp=idle"); end
        @(negedge clk);
        checks++; if (lap_o !== 5'd0 || lap_valid_o !== 1'b0) begin failures++; $display("FAIL lap_cleared got=%0d/%b exp=0/0", lap_o, lap_valid_o); end
        checks++; if (sw_mode_i !== M_CLEAR) begin failures++; $display("FAIL lap_clear_mode got=%b exp=010", sw_mode_i); end
    endtask

    task automatic test_reset_mid_press();
        int   presses;
        logic prev;
        model_en = 1'b0;
        man_mode = M_RUN;
        sw_time_i = 5'd9;
        send(0, 0, 0, 1);
        use_model(M_IDLE);
        send(1, 0, 0, 0);
        presses = button_o ? 1 : 0;
        prev = button_o;
        for (int i = 0; i < 20 && presses < 2; i++) begin
            @(negedge clk);
            if (button_o && !prev) presses++;
            prev = button_o;
        end
        checks++; if (presses !== 2) begin failures++; $display("FAIL rst_second_press got=%0d exp=2", presses); end
        Rst_i = 1'b1;
        #1;
        checks++; if (button_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_btn_busy got=%b/%b exp=0/0", button_o, busy_o); end
        checks++; if (lap_o !== 5'd0 || lap_valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs got lap=%0d v=%b d=%b e=%b exp=0/0/0/0", lap_o, lap_valid_o, done_o, err_o); end
        repeat (2) @(negedge clk);
        Rst_i = 1'b0;
        #2;
        s_rise = rise_cnt;
        s_done = done_cnt;
        repeat (20) @(negedge clk);
        #2;
        checks++; if (done_cnt - s_done !== 0 || rise_cnt - s_rise !== 0) begin failures++; $display("FAIL rst_no_done got done=%0d presses=%0d exp=0/0", done_cnt - s_done, rise_cnt - s_rise); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy_after got=%b exp=0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_start_from_idle();
        test_stop();
        test_priority_and_busy();
        test_timeout_and_illegal();
        test_lap();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
